// File: rtl/alu_cmd_driver_if.sv
//------------------------------------------------------------------------------
// Module      : alu_cmd_driver_if
// Description : Command, ALU-operand, result and status bundle of the ALU driver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_cmd_driver_if #(
    parameter int DATA_W = 48,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [DATA_W-1:0] cmd_c;
    logic              cmd_cin;
    logic [6:0]        cmd_opmode;
    logic [3:0]        cmd_alumode;
    logic              cmd_acc;
    logic              acc_clr;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [DATA_W-1:0] alu_in3;
    logic              alu_carry_in;
    logic [6:0]        alu_opmode;
    logic [3:0]        alu_alumode;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_cout;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  op_count;
    logic              busy;

    // Driver side
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_c, cmd_cin, cmd_opmode, cmd_alumode,
               cmd_acc, acc_clr, alu_out, alu_carry_out, res_ready,
        output cmd_ready, alu_in1, alu_in2, alu_in3, alu_carry_in, alu_opmode,
               alu_alumode, res_valid, res_data, res_cout, acc_q, op_count, busy
    );

    // Control logic and ALU side
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_c, cmd_cin, cmd_opmode, cmd_alumode,
               cmd_acc, acc_clr, alu_out, alu_carry_out, res_ready,
        input  cmd_ready, alu_in1, alu_in2, alu_in3, alu_carry_in, alu_opmode,
               alu_alumode, res_valid, res_data, res_cout, acc_q, op_count, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_driver.sv
//------------------------------------------------------------------------------
// Module      : alu_cmd_driver
// Description : Registers commands into a combinational 48-bit ALU and returns results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_cmd_driver #(
    parameter int DATA_W = 48,
    parameter int CNT_W  = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_cmd_driver_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              cmd_ready_q;
    logic              res_valid_q;
    logic              busy_q;
    logic [DATA_W-1:0] alu_in1_q;
    logic [DATA_W-1:0] alu_in2_q;
    logic [DATA_W-1:0] alu_in3_q;
    logic              alu_cin_q;
    logic [6:0]        alu_opmode_q;
    logic [3:0]        alu_alumode_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_cout_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  op_count_q;
    logic [CNT_W-1:0]  op_count_d;

    assign op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            alu_in3_q     <= '0;
            alu_cin_q     <= 1'b0;
            alu_opmode_q  <= '0;
            alu_alumode_q <= '0;
            res_data_q    <= '0;
            res_cout_q    <= 1'b0;
            acc_q         <= '0;
            op_count_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        alu_in1_q     <= bus.cmd_a;
                        alu_in2_q     <= bus.cmd_b;
                        alu_in3_q     <= bus.cmd_acc ? acc_q : bus.cmd_c;
                        alu_cin_q     <= bus.cmd_cin;
                        alu_opmode_q  <= bus.cmd_opmode;
                        alu_alumode_q <= bus.cmd_alumode;
                        cmd_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_data_q  <= bus.alu_out;
                    res_cout_q  <= bus.alu_carry_out;
                    acc_q       <= bus.alu_out;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        op_count_q  <= op_count_d;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
            // Placed last so a clear overrides the EXEC-edge accumulator load.
            if (bus.acc_clr) begin
                acc_q <= '0;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.busy         = busy_q;
    assign bus.alu_in1      = alu_in1_q;
    assign bus.alu_in2      = alu_in2_q;
    assign bus.alu_in3      = alu_in3_q;
    assign bus.alu_carry_in = alu_cin_q;
    assign bus.alu_opmode   = alu_opmode_q;
    assign bus.alu_alumode  = alu_alumode_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_cout     = res_cout_q;
    assign bus.acc_q        = acc_q;
    assign bus.op_count     = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_cmd_driver
// Description : Randomized self-checking bench for alu_cmd_driver with an adder ALU.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_cmd_driver;
    localparam int DW = 48;
    // Narrow counter keeps the wrap-around scenario short in cycles.
    localparam int CW = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu_cmd_driver_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    alu_cmd_driver #(.DATA_W(DW), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW:0] w_alu_sum;
    assign w_alu_sum = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2}
                     + {1'b0, bus.alu_in3} + {{DW{1'b0}}, bus.alu_carry_in};
    assign bus.alu_out       = w_alu_sum[DW-1:0];
    assign bus.alu_carry_out = w_alu_sum[DW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference state
    logic [DW-1:0] m_acc;
    int            m_cnt;
    logic [DW:0]   m_res;
    logic [DW-1:0] m_a;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic cin,
                         input logic [6:0] opm, input logic [3:0] alum,
                         input logic use_acc, input logic clr_accept,
                         input logic clr_exec);
        logic [DW-1:0] exp_in3;
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("idle_busy", bus.busy, 0);
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_c = c; bus.cmd_cin = cin;
        bus.cmd_opmode = opm; bus.cmd_alumode = alum; bus.cmd_acc = use_acc;
        bus.acc_clr = clr_accept;
        bus.cmd_valid = 1'b1;
        exp_in3 = use_acc ? m_acc : c;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.acc_clr = 1'b0;
        if (clr_accept) m_acc = '0;
        m_a = a;
        chk("alu_in1", bus.alu_in1, a);
        chk("alu_in2", bus.alu_in2, b);
        chk("alu_in3", bus.alu_in3, exp_in3);
        chk("alu_cin", bus.alu_carry_in, cin);
        chk("alu_opmode", bus.alu_opmode, opm);
        chk("alu_alumode", bus.alu_alumode, alum);
        chk("exec_res_valid", bus.res_valid, 0);
        chk("exec_cmd_ready", bus.cmd_ready, 0);
        chk("exec_busy", bus.busy, 1);
        if (clr_accept) chk("acc_clr_on_accept", bus.acc_q, 0);
        m_res = {1'b0, a} + {1'b0, b} + {1'b0, exp_in3} + (DW+1)'(cin);
        bus.acc_clr = clr_exec;
        @(posedge clk); #1;
        bus.acc_clr = 1'b0;
        m_acc = clr_exec ? '0 : m_res[DW-1:0];
        chk("done_res_valid", bus.res_valid, 1);
        chk("done_cmd_ready", bus.cmd_ready, 0);
        chk("res_data", bus.res_data, m_res[DW-1:0]);
        chk("res_cout", bus.res_cout, m_res[DW]);
        chk("acc_q", bus.acc_q, m_acc);
    endtask

    task automatic finish_op(input int stall);
        logic [63:0] r;
        for (int k = 0; k < stall; k++) begin
            r = {$urandom(), $urandom()};
            bus.cmd_a = r[DW-1:0];
            bus.cmd_acc = 1'b0;
            bus.cmd_valid = 1'b1;
            bus.res_ready = 1'b0;
            @(posedge clk); #1;
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_res_data", bus.res_data, m_res[DW-1:0]);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_no_accept", bus.alu_in1, m_a);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CW);
        chk("op_count", bus.op_count, m_cnt);
        chk("post_res_valid", bus.res_valid, 0);
        chk("post_cmd_ready", bus.cmd_ready, 1);
        chk("alu_hold", bus.alu_in1, m_a);
    endtask

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic cin, input logic use_acc,
                         input logic clr_exec, input int stall);
        issue(a, b, c, cin, 7'h35, 4'h0, use_acc, 1'b0, clr_exec);
        finish_op(stall);
    endtask

    initial begin
        logic [63:0] ra, rb, rc;
        int          remaining;
        n_cmp = 0; n_err = 0;
        m_acc = '0; m_cnt = 0; m_res = '0; m_a = '0;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_c = '0;
        bus.cmd_cin = 1'b0; bus.cmd_opmode = '0; bus.cmd_alumode = '0;
        bus.cmd_acc = 1'b0; bus.acc_clr = 1'b0; bus.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);

        // Reset while holding a result in DONE
        issue(48'h1234_5678_9ABC, 48'h1111, 48'h2222, 1'b1, 7'h7F, 4'hF, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_res_data", bus.res_data, 0);
        chk("mid_rst_acc", bus.acc_q, 0);
        chk("mid_rst_op_count", bus.op_count, 0);
        chk("mid_rst_alu_in1", bus.alu_in1, 0);
        chk("mid_rst_alu_in2", bus.alu_in2, 0);
        chk("mid_rst_alu_in3", bus.alu_in3, 0);
        chk("mid_rst_alu_cin", bus.alu_carry_in, 0);
        chk("mid_rst_alu_opmode", bus.alu_opmode, 0);
        chk("mid_rst_alu_alumode", bus.alu_alumode, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        m_acc = '0; m_cnt = 0; m_a = '0;
        @(posedge clk); #1;
        chk("rel_cmd_ready", bus.cmd_ready, 1);

        // Single operation
        do_op(48'd5, 48'd7, 48'd10, 1'b1, 1'b0, 1'b0, 0);
        chk("single_acc", bus.acc_q, 23);

        // Accumulate from zero
        bus.acc_clr = 1'b1;
        @(posedge clk); #1;
        bus.acc_clr = 1'b0;
        m_acc = '0;
        chk("idle_clear", bus.acc_q, 0);
        for (int i = 0; i < 3; i++) begin
            do_op(48'd1, 48'd2, 48'hDEAD, 1'b0, 1'b1, 1'b0, 0);
            chk("accum_result", bus.res_data, 3 * (i + 1));
        end
        chk("accum_count", bus.op_count, 4);

        // Carry-out
        do_op(48'hFFFF_FFFF_FFFF, 48'd1, 48'd0, 1'b0, 1'b0, 1'b0, 0);
        chk("carry_data", bus.res_data, 0);
        chk("carry_cout", bus.res_cout, 1);

        // Backpressure
        do_op(48'd100, 48'd200, 48'd300, 1'b0, 1'b0, 1'b0, 5);

        // Clear colliding with the EXEC capture edge
        do_op(48'd4, 48'd5, 48'd0, 1'b0, 1'b0, 1'b1, 0);
        chk("collide_data", bus.res_data, 9);
        chk("collide_acc", bus.acc_q, 0);

        // Clear colliding with an accumulate accept uses the pre-clear value
        do_op(48'd3, 48'd3, 48'd0, 1'b0, 1'b0, 1'b0, 0);
        issue(48'd1, 48'd1, 48'd0, 1'b0, 7'h05, 4'h3, 1'b1, 1'b1, 1'b0);
        finish_op(1);
        chk("clr_accept_res", bus.res_data, 8);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = {$urandom(), $urandom()};
            issue(ra[DW-1:0], rb[DW-1:0], rc[DW-1:0], ra[63], 7'($urandom()), 4'($urandom()),
                  1'($urandom()), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            finish_op($urandom_range(0, 3));
        end

        // Run the counter up to its wrap point
        remaining = (1 << CW) - m_cnt;
        for (int i = 0; i < remaining; i++) begin
            ra = {$urandom(), $urandom()};
            do_op(ra[DW-1:0], 48'd1, 48'd2, 1'b0, 1'b0, 1'b0, 0);
        end
        chk("wrap_count", bus.op_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
